// File: rtl/mbist_fsm_mc_pkg.sv
// Shared types and limits for the multi-channel MBIST controller.
// Strobe rule for the shared generators lives here as a helper.
package mbist_pkg;

   localparam int NUM_CH_MAX = 16;
   localparam int RD_LAT_MAX = 15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_WAIT,
      ST_CMP,
      ST_NEXT_CH,
      ST_EXIT
   } mbist_fsm_mc_st_t;

   typedef struct packed {
      logic op;
      logic addr;
      logic sti;
      logic pat;
   } run_t;

   // All four end flags set means the final operation: nothing advances.
   function automatic run_t next_run(
      input logic lo,
      input logic la,
      input logic ls,
      input logic lp,
      input logic rev
   );
      run_t r;
      r = '0;
      if (!(lo & la & ls & lp)) begin
         r.op   = 1'b1;
         r.addr = lo & ~(la & rev);
         r.sti  = la & lo;
         r.pat  = la & lo & ls;
      end
      return r;
   endfunction

endpackage

// File: rtl/mbist_fsm_mc_if.sv
// Control bundle between the MBIST FSM and the register block,
// generators and comparator.
interface mbist_fsm_mc_if #(
   parameter int NUM_CH     = 4,
   parameter int ERR_CNT_WD = 8
);
   localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

   logic                  bist_run;
   logic                  bist_error;
   logic                  op_reverse;
   logic                  last_op;
   logic                  last_addr;
   logic                  last_sti;
   logic                  last_pat;
   logic                  cmd_phase;
   logic                  cmp_phase;
   logic                  run_op;
   logic                  run_addr;
   logic                  run_sti;
   logic                  run_pat;
   logic                  run_chan;
   logic [CH_W-1:0]       mem_sel;
   logic                  bist_done;
   logic [NUM_CH-1:0]     bist_fail;
   logic [ERR_CNT_WD-1:0] err_cnt;

   modport master (
      input  bist_run, bist_error, op_reverse,
      input  last_op, last_addr, last_sti, last_pat,
      output cmd_phase, cmp_phase,
      output run_op, run_addr, run_sti, run_pat, run_chan,
      output mem_sel, bist_done, bist_fail, err_cnt
   );

   modport slave (
      output bist_run, bist_error, op_reverse,
      output last_op, last_addr, last_sti, last_pat,
      input  cmd_phase, cmp_phase,
      input  run_op, run_addr, run_sti, run_pat, run_chan,
      input  mem_sel, bist_done, bist_fail, err_cnt
   );

endinterface

// File: rtl/mbist_fsm_mc_err_log.sv
// Per-channel fail flags and error counter; sat=1 holds the count
// at all-ones instead of wrapping.
module mbist_err_log #(
   parameter int NUM_CH     = 4,
   parameter int ERR_CNT_WD = 8,
   parameter int CH_W       = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  log_en,
   input  logic                  sat,
   input  logic [CH_W-1:0]       mem_sel,
   output logic [NUM_CH-1:0]     bist_fail,
   output logic [ERR_CNT_WD-1:0] err_cnt
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         bist_fail <= '0;
         err_cnt   <= '0;
      end else if (log_en) begin
         bist_fail <= bist_fail | (NUM_CH'(1) << mem_sel);
         if (!(sat && (&err_cnt)))
            err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mbist_fsm_mc.sv
// Multi-channel MBIST main FSM: CMD / WAIT / CMP per operation, channels in turn.
// MBIST_CONT_ON_ERR_EN: an error skips to the next channel instead of exiting.
module mbist_fsm_mc
   import mbist_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int RD_LAT     = 1,
   parameter int ERR_CNT_WD = 8
) (
   input logic          clk,
   input logic          rst,
   mbist_fsm_mc_if.master bus
);

   localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = RD_LAT > 0 ? $clog2(RD_LAT + 1) : 1;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   mbist_fsm_mc_st_t st;
   logic [CNT_W-1:0] wait_cnt;
   logic             cmd_q;
   logic             cmp_q;
   logic             chan_q;
   logic             done_q;
   logic [CH_W-1:0]  sel_q;
   run_t             run_q;
   run_t             nxt_run;
   logic             all_last;
   logic             log_en;
   logic             clr;

   assign all_last = bus.last_op & bus.last_addr
                   & bus.last_sti & bus.last_pat;
   assign nxt_run  = next_run(bus.last_op, bus.last_addr,
                              bus.last_sti, bus.last_pat,
                              bus.op_reverse);
   assign log_en   = bus.bist_run & bus.bist_error & (st == ST_CMP);
   assign clr      = bus.bist_run & (st == ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= ST_IDLE;
         wait_cnt <= '0;
         cmd_q    <= 1'b0;
         cmp_q    <= 1'b0;
         run_q    <= '0;
         chan_q   <= 1'b0;
         done_q   <= 1'b0;
         sel_q    <= '0;
      end else begin
         cmd_q  <= 1'b0;
         cmp_q  <= 1'b0;
         run_q  <= '0;
         chan_q <= 1'b0;
         if (!bus.bist_run) begin
            st    <= ST_IDLE;
            sel_q <= '0;
         end else begin
            unique case (st)
               ST_IDLE: begin
                  done_q <= 1'b0;
                  sel_q  <= '0;
                  st     <= ST_CMD;
                  cmd_q  <= 1'b1;
               end
               ST_CMD: begin
                  if (RD_LAT == 0) begin
                     st    <= ST_CMP;
                     cmp_q <= 1'b1;
                     run_q <= nxt_run;
                  end else begin
                     st       <= ST_WAIT;
                     wait_cnt <= CNT_W'(RD_LAT - 1);
                  end
               end
               ST_WAIT: begin
                  if (wait_cnt == '0) begin
                     st    <= ST_CMP;
                     cmp_q <= 1'b1;
                     run_q <= nxt_run;
                  end else begin
                     wait_cnt <= wait_cnt - 1'b1;
                  end
               end
               ST_CMP: begin
                  if (bus.bist_error) begin
`ifdef MBIST_CONT_ON_ERR_EN
                     st     <= ST_NEXT_CH;
                     chan_q <= 1'b1;
`else
                     st     <= ST_EXIT;
                     done_q <= 1'b1;
`endif
                  end else if (all_last) begin
                     st     <= ST_NEXT_CH;
                     chan_q <= 1'b1;
                  end else begin
                     st    <= ST_CMD;
                     cmd_q <= 1'b1;
                  end
               end
               ST_NEXT_CH: begin
                  if (sel_q == LAST_CH) begin
                     st     <= ST_EXIT;
                     done_q <= 1'b1;
                  end else begin
                     sel_q <= sel_q + 1'b1;
                     st    <= ST_CMD;
                     cmd_q <= 1'b1;
                  end
               end
               ST_EXIT: done_q <= 1'b1;
               default: st <= ST_IDLE;
            endcase
         end
      end
   end

   mbist_err_log #(
      .NUM_CH     (NUM_CH),
      .ERR_CNT_WD (ERR_CNT_WD),
      .CH_W       (CH_W)
   ) u_err_log (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .log_en    (log_en),
      .sat       (1'b1),
      .mem_sel   (sel_q),
      .bist_fail (bus.bist_fail),
      .err_cnt   (bus.err_cnt)
   );

   assign bus.cmd_phase = cmd_q;
   assign bus.cmp_phase = cmp_q;
   assign bus.run_op    = run_q.op;
   assign bus.run_addr  = run_q.addr;
   assign bus.run_sti   = run_q.sti;
   assign bus.run_pat   = run_q.pat;
   assign bus.run_chan  = chan_q;
   assign bus.mem_sel   = sel_q;
   assign bus.bist_done = done_q;

endmodule
